// File: rtl/cpu32_io_pkg.sv
// Shared definitions for the UART receiver: FSM states, status bit positions
// and register addresses.
package cpu32_io_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  localparam int unsigned StatNotEmpty = 0;
  localparam int unsigned StatOvr      = 1;
  localparam int unsigned StatFerr     = 2;
  localparam int unsigned StatFull     = 3;

  localparam logic AddrData   = 1'b0;
  localparam logic AddrStatus = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with extra-MSB pointers; a pop frees a slot for a same-cycle push.
module uart_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a receive FIFO and a two-register read interface
// (data, status with sticky overrun / framing-error bits).
module uart_rx
  import cpu32_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       cs,
  input  logic       re,
  input  logic       addr,
  output logic [7:0] rdata,
  output logic       irq
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            armed_q, armed_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d;
  logic            push, ferr_set, ovr_set, cnt_exp;
  logic            data_rd, stat_rd;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout, status;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign cnt_exp = (cnt_q == CntW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A start edge only counts once the line has been seen idle-high.
        if (!armed_q) begin
          armed_d = rx_sync_q;
        end else if (!rx_sync_q) begin
          state_d = StStart;
          cnt_d   = CntW'(CLKS_PER_BIT / 2);
        end
      end
      StStart: begin
        if (!cnt_exp) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rx_sync_q) begin
          state_d   = StData;
          cnt_d     = CntW'(CLKS_PER_BIT);
          bit_idx_d = 3'd0;
        end else begin
          state_d = StIdle;
          armed_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StData: begin
        if (!cnt_exp) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d[bit_idx_q] = rx_sync_q;
          cnt_d              = CntW'(CLKS_PER_BIT);
          if (bit_idx_q == 3'd7) state_d = StStop;
          else bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (!cnt_exp) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          push     = rx_sync_q;
          ferr_set = ~rx_sync_q;
          state_d  = StIdle;
          armed_d  = 1'b0;
          cnt_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_rd = cs & re & (addr == AddrData);
  assign stat_rd = cs & re & (addr == AddrStatus);

  // A pop on the same edge makes room, so only an unmatched push overruns.
  assign ovr_set = push & fifo_full & ~data_rd;
  assign ovr_d   = ovr_set | (ovr_q & ~stat_rd);
  assign ferr_d  = ferr_set | (ferr_q & ~stat_rd);

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (data_rd),
    .din  (shift_q),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    status               = 8'h00;
    status[StatNotEmpty] = ~fifo_empty;
    status[StatOvr]      = ovr_q;
    status[StatFerr]     = ferr_q;
    status[StatFull]     = fifo_full;
  end

  always_comb begin
    rdata = 8'h00;
    if (data_rd)      rdata = fifo_empty ? 8'h00 : fifo_dout;
    else if (stat_rd) rdata = status;
  end

  assign irq = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based receiver model.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, rx, cs, re, addr;
  logic [7:0] rdata;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .cs   (cs),
    .re   (re),
    .addr (addr),
    .rdata(rdata),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (q.size() != 0);
    s[1] = m_ovr;
    s[2] = m_ferr;
    s[3] = (q.size() == DEPTH);
    return s;
  endfunction

  task automatic m_rx(input logic [7:0] b, input logic stop_bit);
    if (!stop_bit) m_ferr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic read_reg(input logic a, output logic [7:0] v);
    cs = 1'b1; re = 1'b1; addr = a;
    #1 v = rdata;
    @(negedge clk);
    cs = 1'b0; re = 1'b0; addr = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = m_status();
    read_reg(1'b1, v);
    chk(tag, v, e);
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic check_data(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    e = (q.size() != 0) ? q.pop_front() : 8'h00;
    read_reg(1'b0, v);
    chk(tag, v, e);
  endtask

  // Sends one frame plus idle time. Optionally issues a data read at negedge
  // index rd_at; reports the first index where irq was seen rising.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rd_at,
                            output int rise_at, output logic [7:0] rd_val);
    logic [9:0] frame;
    logic       was_low;
    frame   = {stop_bit, b, 1'b0};
    rise_at = -1;
    rd_val  = 8'h00;
    was_low = (irq === 1'b0);
    for (int k = 0; k < 12 * CPB; k++) begin
      if (was_low && rise_at < 0 && irq === 1'b1) rise_at = k;
      rx = (k < 10 * CPB) ? frame[k / CPB] : 1'b1;
      if (k == rd_at) begin
        cs = 1'b1; re = 1'b1; addr = 1'b0;
        #1 rd_val = rdata;
      end else begin
        cs = 1'b0; re = 1'b0; addr = 1'b0;
      end
      @(negedge clk);
    end
    cs = 1'b0; re = 1'b0;
  endtask

  initial begin
    int         rise, lat, n;
    logic [7:0] v, b, rdv;
    logic       sb;
    logic [9:0] frame;

    reset = 1'b0; rx = 1'b1; cs = 1'b0; re = 1'b0; addr = 1'b0;
    #2;
    chk("irq_in_reset", {7'b0, irq}, 8'h00);
    cs = 1'b1; re = 1'b1; addr = 1'b1;
    #1 chk("status_in_reset", rdata, 8'h00);
    addr = 1'b0;
    #1 chk("data_in_reset", rdata, 8'h00);
    cs = 1'b0; re = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_status("status_after_reset");

    // Single byte; also learns the stop-sample edge for the collision test.
    send_frame(8'h41, 1'b1, -1, rise, rdv);
    m_rx(8'h41, 1'b1);
    chk("irq_after_41", {7'b0, irq}, 8'h01);
    n_vec++;
    assert (rise >= 9 * CPB + 2 && rise <= 10 * CPB + 2) else begin
      n_err++;
      $error("FAIL push_latency: observed %0d expected %0d..%0d", rise, 9 * CPB + 2, 10 * CPB + 2);
    end
    lat = (rise > 0) ? rise : 3 + CPB / 2 + 9 * CPB;
    check_status("status_41");
    check_data("data_41");
    check_status("status_41_drained");
    chk("irq_41_drained", {7'b0, irq}, 8'h00);

    // Deselected / no-strobe accesses have no effect and read 0.
    cs = 1'b0; re = 1'b1; addr = 1'b1;
    #1 chk("rdata_cs_low", rdata, 8'h00);
    cs = 1'b1; re = 1'b0;
    #1 chk("rdata_re_low", rdata, 8'h00);
    cs = 1'b0;
    @(negedge clk);

    // Short glitch on the line.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("irq_glitch", {7'b0, irq}, 8'h00);
    check_status("status_glitch");

    // Framing error.
    send_frame(8'h55, 1'b0, -1, rise, rdv);
    m_rx(8'h55, 1'b0);
    chk("irq_ferr", {7'b0, irq}, 8'h00);
    check_status("status_ferr");
    check_status("status_ferr_cleared");

    // Overrun.
    for (int i = 0; i < 5; i++) begin
      b = 8'h30 + 8'(i);
      send_frame(b, 1'b1, -1, rise, rdv);
      m_rx(b, 1'b1);
    end
    check_status("status_ovr");
    for (int i = 0; i < 5; i++) check_data("data_ovr");
    check_status("status_ovr_cleared");

    // Push while full with a pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      b = 8'h30 + 8'(i);
      send_frame(b, 1'b1, -1, rise, rdv);
      m_rx(b, 1'b1);
    end
    send_frame(8'h34, 1'b1, lat - 1, rise, rdv);
    v = q.pop_front();
    chk("data_collide", rdv, v);
    m_rx(8'h34, 1'b1);
    check_status("status_collide");
    for (int i = 0; i < 4; i++) check_data("data_collide_drain");
    check_status("status_collide_drained");

    // Randomized bursts.
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        b  = 8'($urandom);
        sb = ($urandom_range(0, 5) != 0);
        send_frame(b, sb, -1, rise, rdv);
        m_rx(b, sb);
      end
      check_status("status_rand");
      while (q.size() != 0) check_data("data_rand");
      check_data("data_rand_empty");
      check_status("status_rand_drained");
    end

    // Reset in the middle of bit 3 of 0xA5.
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 4 * CPB + CPB / 2; k++) begin
      rx = frame[k / CPB];
      @(negedge clk);
    end
    reset = 1'b0;
    rx    = 1'b1;
    #1 chk("irq_mid_reset", {7'b0, irq}, 8'h00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8 * CPB) @(negedge clk);
    check_status("status_after_abort");
    send_frame(8'h3C, 1'b1, -1, rise, rdv);
    m_rx(8'h3C, 1'b1);
    check_status("status_3c");
    check_data("data_3c");
    check_status("status_3c_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; SHALL be an even value >= 4.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; SHALL be a power of two >= 2.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  asynchronous serial line: 8N1, LSB first, idle high.
REQ-006 cs  input  1  bus select for this device.
REQ-007 re  input  1  bus read strobe, sampled on clk.
REQ-008 addr  input  1  register select: 0 = data, 1 = status.
REQ-009 rdata  output  8  combinational read data for the selected register.
REQ-010 irq  output  1  high whenever the FIFO is non-empty.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer SHALL reset to 1.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-013 In IDLE, the FSM SHALL arm only after the synchronized rx has been observed high; a subsequent low sample -> START, with the bit counter loaded to CLKS_PER_BIT/2.
REQ-014 START: when the counter expires, rx low -> DATA (counter = CLKS_PER_BIT, bit index 0); rx high -> glitch, return to IDLE with nothing recorded.
REQ-015 DATA: rx SHALL be sampled every CLKS_PER_BIT cycles into shift[bit index]; after bit 7 -> STOP.
REQ-016 STOP: at the mid-bit sample, rx high -> push the byte; rx low -> set the sticky FERR bit, discard the byte; both paths -> IDLE (disarmed until rx is high).
REQ-017 A pushed byte SHALL be visible (status bit0 = 1, irq = 1) on the cycle after the stop-bit sample edge.
REQ-018 Status rdata SHALL be {4'b0, FULL, FERR, OVR, NOT_EMPTY} in bits [7:0].
REQ-019 Data read (cs & re & addr=0): rdata SHALL show the FIFO head combinationally; the pop SHALL occur on that clk edge.
REQ-020 A data read while the FIFO is empty SHALL return 0x00 and leave the pointers unchanged.
REQ-021 Push while full with no pop in the same cycle: the new byte SHALL be dropped, the sticky OVR bit set, and existing contents kept.
REQ-022 Push and pop in the same cycle while full: both SHALL succeed, OVR unchanged.
REQ-023 Status read (cs & re & addr=1): rdata SHALL return the current OVR/FERR; both SHALL clear on that edge; a same-cycle set SHALL win over the clear.
REQ-024 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be derived from the pointer MSB and the remaining bits.
REQ-025 cs low, or re low: no side effects; rdata SHALL be 0x00.

Reset
REQ-026 reset low SHALL immediately force: FSM = IDLE (disarmed), counters = 0, FIFO empty, OVR = FERR = 0, irq = 0, rdata = 0x00.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, no byte from that frame SHALL be pushed.

Structure
REQ-028 Package cpu32_io_pkg SHALL hold the FSM state enum, the status bit-position constants and the register address constants.
REQ-029 The FIFO SHALL be one sub-module, uart_rx_fifo (push, pop, din, dout, full, empty).
REQ-030 Target size: 120-400 RTL lines.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-031 Send 0x41 -> status 0x01 and irq = 1; data read = 0x41; status then 0x00 and irq = 0.
REQ-032 rx pulsed low for 4 clocks -> no push; status stays 0x00.
REQ-033 Send 0x55 with stop bit = 0 -> status 0x04; FIFO empty; the next status read returns 0x04, then 0x00.
REQ-034 Send 0x30..0x34 with no reads -> status 0x0B; data reads return 0x30..0x33, then 0x00; OVR clears after a status read.
REQ-035 FIFO full, with a data read on the same edge as the fifth stop-bit sample -> no OVR; reads return 0x31..0x34.
REQ-036 Reset asserted at bit 3 of 0xA5 and released with rx held high -> status 0x00; a following 0x3C is received correctly.
